// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter merging NUM_INPUTS AXI-Stream sources onto one output.
// A granted source owns the output until its tlast beat; an idle gap then follows each frame.
//
// state   | meaning
// IDLE    | no grant; picks the next valid source round-robin from last_grant+1
// FORWARD | grant_index owns the output; beats pass straight through
// GAP     | post-frame wait of GAP_CYCLES cycles, all sources held off
module frame_stream_arbiter #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 20,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]            s_axis_tready,
    input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_index,
    output logic                             frame_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        GAP     = 2'd2
    } state_t;

    localparam int          CW       = IDX_W + 1;
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    state_t           state         = IDLE;
    logic             grant_valid_r = 1'b0;
    logic [IDX_W-1:0] grant_index_r = '0;
    logic [IDX_W-1:0] last_grant    = IDX_W'(NUM_INPUTS - 1);
    logic [31:0]      gap_counter   = '0;
    logic             frame_done_r  = 1'b0;

    logic [IDX_W-1:0] pick;
    logic [CW-1:0]    cand;
    logic             fwd;

    assign grant_valid = grant_valid_r;
    assign grant_index = grant_index_r;
    assign frame_done  = frame_done_r;

    // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        pick = last_grant;
        cand = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = CW'(last_grant) + CW'(k);
            if (cand >= CW'(NUM_INPUTS)) begin
                cand = cand - CW'(NUM_INPUTS);
            end
            if (s_axis_tvalid[cand[IDX_W-1:0]]) begin
                pick = cand[IDX_W-1:0];
            end
        end
    end

    // Reset gates the datapath combinationally so an aborted frame moves no further beats.
    assign fwd = (state == FORWARD) && !rst;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (fwd) begin
            m_axis_tdata                 = s_axis_tdata[grant_index_r*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid                = s_axis_tvalid[grant_index_r];
            m_axis_tlast                 = s_axis_tlast[grant_index_r];
            s_axis_tready[grant_index_r] = m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_valid_r <= 1'b0;
            grant_index_r <= '0;
            last_grant    <= IDX_W'(NUM_INPUTS - 1);
            gap_counter   <= '0;
            frame_done_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_index_r <= pick;
                        grant_valid_r <= 1'b1;
                        state         <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        last_grant    <= grant_index_r;
                        grant_valid_r <= 1'b0;
                        frame_done_r  <= 1'b1;
                        gap_counter   <= '0;
                        state         <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    gap_counter <= gap_counter + 32'd1;
                    if (gap_counter == GAP_LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Randomized scoreboard bench for frame_stream_arbiter: per-source frame stores, a frame-level
// round-robin reference model, and a monitor that pops expected beats on every output handshake.
module tb_frame_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int G   = 20;
    localparam int MEM = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tready, m_tlast;
    logic            grant_valid, frame_done;
    logic [1:0]      grant_index;

    frame_stream_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .grant_valid(grant_valid), .grant_index(grant_index), .frame_done(frame_done)
    );

    // Second instance with no inter-frame gap.
    logic        rst_z;
    logic [15:0] z_tdata;
    logic [1:0]  z_tvalid, z_tready, z_tlast;
    logic [7:0]  zm_tdata;
    logic        zm_tvalid, zm_tready, zm_tlast, z_gv, z_fd;
    logic [0:0]  z_gi;

    frame_stream_arbiter #(.NUM_INPUTS(2), .DATA_WIDTH(8), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst_z),
        .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tready(z_tready),
        .s_axis_tlast(z_tlast),
        .m_axis_tdata(zm_tdata), .m_axis_tvalid(zm_tvalid), .m_axis_tready(zm_tready),
        .m_axis_tlast(zm_tlast),
        .grant_valid(z_gv), .grant_index(z_gi), .frame_done(z_fd)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Source frame stores: {last, data} per beat, consumed from head on handshake.
    logic [DW:0] src_mem [N][MEM];
    int          src_head [N];
    int          src_tail [N];

    int  vprob      = 100;
    int  ready_mode = 0;
    int  cyc        = 0;
    bit  rst_req    = 1'b1;

    // Reference model state (frame level).
    bit  m_busy  = 1'b0;
    int  m_owner = 0;
    int  m_last  = N - 1;
    int  m_cool  = 0;
    bit  m_done  = 1'b0;

    logic [DW+2:0] exp_q[$];
    int            dut_grants[$];
    int            fd_count  = 0;
    int            hs_count  = 0;
    int            hs_first  = -1;
    int            hs_last   = -1;
    logic          gv_prev   = 1'b0;

    task automatic add_frame(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            src_mem[src][src_tail[src]] = {(b == len - 1), 8'($urandom)};
            src_tail[src]++;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] != src_tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int grant_code();
        int c = 0;
        foreach (dut_grants[k]) c = c * 10 + dut_grants[k] + 1;
        return c;
    endfunction

    task automatic begin_phase();
        dut_grants.delete();
        fd_count = 0;
        hs_count = 0;
        hs_first = -1;
        hs_last  = -1;
    endtask

    task automatic cycle_checks();
        logic [N-1:0] er;
        bit           fwd;
        check("grant_valid", grant_valid, m_busy);
        if (m_busy) check("grant_index", grant_index, m_owner);
        check("frame_done", frame_done, m_done);
        fwd = m_busy && !rst;
        check("m_tvalid", m_tvalid, fwd ? s_tvalid[m_owner] : 1'b0);
        er = '0;
        if (fwd) er[m_owner] = m_tready;
        check("s_tready", s_tready, er);
        if (fwd) check("m_tlast_copy", m_tlast, s_tlast[m_owner]);
        else     check("m_idle_zero", {m_tlast, m_tdata}, 0);
    endtask

    task automatic model_update();
        int c;
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_last = N - 1;
            m_cool = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (s_tvalid[m_owner] && m_tready && src_mem[m_owner][src_head[m_owner]][DW]) begin
                m_busy = 1'b0;
                m_last = m_owner;
                m_cool = G;
                m_done = 1'b1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (|s_tvalid) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (s_tvalid[c]) break;
            end
            m_owner = c;
            m_busy  = 1'b1;
            for (int p = src_head[c]; p < src_tail[c]; p++) begin
                exp_q.push_back({2'(c), src_mem[c][p]});
                if (src_mem[c][p][DW]) break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst      = rst_req;
        m_tready = (ready_mode == 0) ? 1'b1 : (((cyc / 10) % 2) == 0);
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) begin
                s_tdata[i*DW +: DW] = src_mem[i][src_head[i]][DW-1:0];
                s_tlast[i]          = src_mem[i][src_head[i]][DW];
                s_tvalid[i]         = ($urandom_range(99) < vprob);
            end else begin
                s_tdata[i*DW +: DW] = '0;
                s_tlast[i]          = 1'b0;
                s_tvalid[i]         = 1'b0;
            end
        end
        @(negedge clk);
        cycle_checks();
        model_update();
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) src_head[i]++;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((!all_empty() || m_busy || m_cool != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        step();
    endtask

    // Scoreboard monitor: pops one expected beat per output handshake.
    always @(negedge clk) begin
        logic [DW+2:0] e;
        if (grant_valid && !gv_prev) dut_grants.push_back(int'(grant_index));
        gv_prev = grant_valid;
        if (frame_done === 1'b1) fd_count++;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            hs_count++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h expected=none t=%0t", m_tdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", m_tdata, e[DW-1:0]);
                check("out_last", m_tlast, e[DW]);
                check("out_src", grant_index, e[DW+2:DW+1]);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        rst_z = 1'b1; z_tdata = {8'hB1, 8'hA0}; z_tvalid = '0; z_tlast = '0; zm_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end

        repeat (3) step();
        rst_req = 1'b0;
        step();
        check("reset_grant_valid", grant_valid, 0);
        check("reset_grant_index", grant_index, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_tready", s_tready, 0);

        // Round-robin between two continuously valid sources.
        begin_phase();
        add_frame(0, 5); add_frame(1, 7); add_frame(0, 5); add_frame(1, 7);
        drain(3000);
        check("rr_order", grant_code(), 1212);
        check("rr_frames", fd_count, 4);

        // Single source, three 64-beat frames, with the idle span between frames.
        begin_phase();
        add_frame(0, 64); add_frame(0, 64); add_frame(0, 64);
        drain(3000);
        check("single_frames", fd_count, 3);
        check("single_beats", hs_count, 192);
        check("single_span", hs_last - hs_first + 1, 192 + 2 * (G + 1));
        check("single_order", grant_code(), 111);

        // Wrap-around: last grant 3, then sources 1 and 2 request together.
        begin_phase();
        add_frame(3, 4);
        drain(2000);
        check("wrap_src3", grant_code(), 4);
        begin_phase();
        add_frame(1, 3); add_frame(2, 3);
        drain(2000);
        check("wrap_order", grant_code(), 23);

        // Random frames with valid gaps and output backpressure toggling every 10 cycles.
        begin_phase();
        vprob = 70; ready_mode = 1;
        for (int f = 0; f < 12; f++) add_frame(int'($urandom_range(N - 1)), int'($urandom_range(20, 1)));
        add_frame(2, 1); add_frame(3, 1);
        drain(20000);
        check("rand_frames", fd_count, 14);

        // Reset at beat 10 of a 64-beat frame; remaining beats follow after re-arbitration.
        begin_phase();
        vprob = 100; ready_mode = 0;
        base = src_head[0];
        add_frame(0, 64);
        n = 0;
        while (src_head[0] < base + 10 && n < 500) begin
            step();
            n++;
        end
        check("reset_beat_reached", src_head[0], base + 10);
        rst_req = 1'b1;
        step();
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_tready", s_tready, 0);
        step();
        rst_req = 1'b0;
        drain(2000);
        check("midrst_beats", hs_count, 64);
        check("midrst_frames", fd_count, 1);
        check("midrst_regrant", grant_code(), 11);

        // Zero-gap instance: one-beat frames from both sources alternate with one idle cycle.
        z_tvalid = 2'b11;
        z_tlast  = 2'b11;
        @(posedge clk);
        #1 rst_z = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("zgap_valid", zm_tvalid, k % 2);
            if (k % 2 == 1) begin
                check("zgap_index", z_gi, ((k - 1) / 2) % 2);
                check("zgap_data", zm_tdata, (((k - 1) / 2) % 2 == 0) ? 8'hA0 : 8'hB1);
                check("zgap_last", zm_tlast, 1);
            end
            check("zgap_done", z_fd, (k >= 2) && (k % 2 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
